fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage that produces the IF/ID pipeline register consumed by the decode stage. It holds the PC, issues one-at-a-time instruction-memory reads over a valid/ready request channel, and accepts responses on a valid-only response channel. It applies decode back-pressure through a one-entry holding buffer, and squashes wrong-path fetches on a taken branch or jump from EX. It sits between instruction memory and the decode stage and is the transmitter side of the `if_id_*` interface.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `NOP_INST`, default 32'h0000_0013 (addi x0,x0,0): IR value driven whenever `if_id_valid_inst`=0.
- `clk`, in, 1: single clock, all state on rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low.
- `id_stall`, in, 1: decode cannot accept; the IF/ID register holds.
- `ex_take_branch`, in, 1: redirect fetch (taken branch, JAL, or JALR).
- `ex_target_pc`, in, 32: redirect target; bits [1:0] ignored and treated as 0.
- `imem_req_valid`, out, 1: read request valid.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_req_addr`, out, 32: word-aligned fetch address.
- `imem_rsp_valid`, in, 1: read data valid, one pulse per accepted request, in order.
- `imem_rsp_data`, in, 32: instruction word.
- `if_id_IR`, out, 32: instruction to decode.
- `if_id_PC`, out, 32: PC of `if_id_IR`.
- `if_id_NPC`, out, 32: `if_id_PC`+4.
- `if_id_valid_inst`, out, 1: IF/ID slot holds a real instruction.

## Operation
- **State**
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - Hold buffer: `hold_valid`, `hold_ir`, `hold_pc`.
  - FSM with states S_REQ, S_WAIT, S_DROP.
- **S_REQ**
  - `imem_req_valid` = !`hold_valid`; `imem_req_addr` = `pc`.
  - On accept (valid&ready): `req_pc`<=`pc`, `pc`<=`pc`+4, go to S_WAIT.
- **S_WAIT**
  - On `imem_rsp_valid`:
    - If !`id_stall`, the response loads IF/ID.
    - If `id_stall`, the response loads the hold buffer.
  - Back-to-back request: `imem_req_valid` = `imem_rsp_valid` & !`id_stall` & !`ex_take_branch`, address `pc`.
    - If accepted, stay in S_WAIT with `req_pc`<=`pc`, `pc`<=`pc`+4.
    - Otherwise go to S_REQ.
- **S_DROP**
  - `imem_req_valid`=0.
  - The next `imem_rsp_valid` is discarded, then go to S_REQ.
- **Redirect** (`ex_take_branch`=1) overrides everything else in that cycle.
  - `pc`<=`{ex_target_pc[31:2],2'b00}`.
  - IF/ID squashed: valid<=0, IR<=`NOP_INST`.
  - `hold_valid`<=0.
  - Next state:
    - From S_REQ with no accept: stay in S_REQ. The request address may change only in this case.
    - From S_REQ with accept in the same cycle: go to S_DROP.
    - From S_WAIT without `imem_rsp_valid`: go to S_DROP.
    - From S_WAIT with `imem_rsp_valid` in the same cycle: the response is discarded, go to S_REQ.
    - From S_DROP: stay in S_DROP, `pc` updated. If a response arrives in that same cycle, it is the dropped one: discard it and go to S_REQ.
- **IF/ID update priority**
  1. Redirect squash.
  2. Else if `id_stall`: hold.
  3. Else if `hold_valid`: load the hold buffer and clear it.
  4. Else if the S_WAIT response is present: load it.
  5. Otherwise: bubble (valid=0, IR=`NOP_INST`, PC/NPC unchanged).
- The hold buffer is never full while a request is outstanding, so a response never arrives with `hold_valid`=1.
- **Arithmetic**: all PC adds are 32-bit modulo; 32'hFFFF_FFFC+4 = 0.

## Timing
- **Reset values**
  - `pc`=`RESET_PC`, FSM=S_REQ, `hold_valid`=0.
  - `if_id_valid_inst`=0, `if_id_IR`=`NOP_INST`, `if_id_PC`=`RESET_PC`, `if_id_NPC`=`RESET_PC`+4.
  - `imem_req_valid` is 0 during reset and 1 in the first cycle after release.
- **Handshake**
  - Once raised, `imem_req_valid` and `imem_req_addr` stay stable until accepted. The only exception is a redirect in S_REQ.
- **Latency and throughput**
  - Response in cycle N appears on `if_id_*` in cycle N+1 when not stalled.
  - With zero-wait memory (ready=1, response one cycle after accept), sustained throughput is 1 instruction per cycle.
- **Squash timing**: redirect in cycle N means `if_id_valid_inst`=0 in N+1; the first target-path instruction is valid no earlier than N+3.
- `id_stall` and `ex_take_branch` act in the same cycle they are sampled; there are no combinational paths from them to `if_id_*`.
- **Reset mid-operation**: asserting reset discards any outstanding request state. The memory model must also drop in-flight responses on reset.

## Structure
- Add to sys_defs.vh:
  - the FSM state encoding (`FETCH_S_REQ`, `FETCH_S_WAIT`, `FETCH_S_DROP`);
  - `NOOP_INST` 32'h0000_0013;
  - the PC width.
- One natural sub-module: `fetch_hold_buf`, a one-entry IR/PC holding register with load, drain, and flush.

## Test plan
- **Reset and single-cycle memory**: release reset with ready=1 and response one cycle after accept → addresses 0,4,8,…; `if_id_PC` 0,4,8 on consecutive cycles, valid=1, NPC=PC+4.
- **Stall**: stall 3 cycles while the response for PC 8 arrives → IF/ID holds PC 4; PC 8 goes to the hold buffer; no request issues; after the stall, PC 8 then PC 12 follow with no loss or duplication.
- **Redirect while waiting**: redirect to 32'h0000_0103 while the PC 12 request is outstanding → the PC 12 response is dropped; next request address is 32'h0000_0100; the cycle after the redirect has valid=0 and IR=32'h0000_0013.
- **Redirect with simultaneous response**: redirect to 0x40 in the same cycle the response arrives → the response is discarded; S_REQ issues 0x40 the next cycle.
- **Wrap-around and slow memory**: PC 32'hFFFF_FFFC with ready low for 4 cycles → address stable while waiting; next address 0.
- **Reset mid-wait**: assert reset while in S_WAIT → outputs return to reset values immediately; first post-reset address is `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: widths, FSM encoding,
// the IF/ID payload type and PC arithmetic helpers.
package fetch_stage_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] FETCH_S_REQ  = 2'd0;
    localparam logic [ST_W-1:0] FETCH_S_WAIT = 2'd1;
    localparam logic [ST_W-1:0] FETCH_S_DROP = 2'd2;

    // addi x0,x0,0
    localparam logic [INST_W-1:0] NOOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] ir;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // Sequential PC, modulo 2^32
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel: valid/ready read request plus valid-only,
// in-order read response.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry IR/PC holding register that parks a response arriving while
// decode is stalled. Flush wins over load, load wins over drain.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic         valid,
    output fetch_entry_t entry
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= wr_entry;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read at a time, a one-entry
// buffer absorbing decode stalls, and wrong-path squash on EX redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = NOOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_stall,
    input  logic              ex_take_branch,
    input  logic [PC_W-1:0]   ex_target_pc,
    fetch_stage_if.master     imem,
    output logic [INST_W-1:0] if_id_IR,
    output logic [PC_W-1:0]   if_id_PC,
    output logic [PC_W-1:0]   if_id_NPC,
    output logic              if_id_valid_inst
);

    logic [ST_W-1:0] state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [PC_W-1:0] req_pc, req_pc_n;
    logic            req_valid_c;
    logic            accept_c;
    logic            rsp_take_c;
    logic            hold_valid;
    fetch_entry_t    hold_entry;
    fetch_entry_t    hold_wr;

    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_req_addr  = pc;

    assign rsp_take_c = (state == FETCH_S_WAIT) && imem.imem_rsp_valid;
    assign hold_wr    = '{ir: imem.imem_rsp_data, pc: req_pc};

    // Request generation and next-state; a redirect overrides the normal flow
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_pc_n    = req_pc;
        req_valid_c = 1'b0;

        case (state)
            FETCH_S_REQ:  req_valid_c = !hold_valid;
            FETCH_S_WAIT: req_valid_c = imem.imem_rsp_valid && !id_stall && !ex_take_branch;
            default:      req_valid_c = 1'b0;
        endcase
        if (!rst) begin
            req_valid_c = 1'b0;
        end

        accept_c = req_valid_c && imem.imem_req_ready;
        if (accept_c) begin
            req_pc_n = pc;
            pc_n     = pc_next(pc);
        end

        case (state)
            FETCH_S_REQ:  if (accept_c) state_n = FETCH_S_WAIT;
            FETCH_S_WAIT: if (imem.imem_rsp_valid) state_n = accept_c ? FETCH_S_WAIT : FETCH_S_REQ;
            FETCH_S_DROP: if (imem.imem_rsp_valid) state_n = FETCH_S_REQ;
            default:      state_n = FETCH_S_REQ;
        endcase

        // WAIT and DROP redirect alike: a same-cycle response is the stale one
        if (ex_take_branch) begin
            pc_n = pc_align(ex_target_pc);
            case (state)
                FETCH_S_REQ: state_n = accept_c ? FETCH_S_DROP : FETCH_S_REQ;
                default:     state_n = imem.imem_rsp_valid ? FETCH_S_REQ : FETCH_S_DROP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH_S_REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            req_pc <= req_pc_n;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (rsp_take_c && id_stall && !ex_take_branch),
        .drain    (hold_valid && !id_stall && !ex_take_branch),
        .flush    (ex_take_branch),
        .wr_entry (hold_wr),
        .valid    (hold_valid),
        .entry    (hold_entry)
    );

    // IF/ID register: squash, hold, drain buffer, take response, else bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_valid_inst <= 1'b0;
            if_id_IR         <= NOP_INST;
            if_id_PC         <= RESET_PC;
            if_id_NPC        <= pc_next(RESET_PC);
        end else if (ex_take_branch) begin
            if_id_valid_inst <= 1'b0;
            if_id_IR         <= NOP_INST;
        end else if (id_stall) begin
            if_id_valid_inst <= if_id_valid_inst;
        end else if (hold_valid) begin
            if_id_valid_inst <= 1'b1;
            if_id_IR         <= hold_entry.ir;
            if_id_PC         <= hold_entry.pc;
            if_id_NPC        <= pc_next(hold_entry.pc);
        end else if (rsp_take_c) begin
            if_id_valid_inst <= 1'b1;
            if_id_IR         <= imem.imem_rsp_data;
            if_id_PC         <= req_pc;
            if_id_NPC        <= pc_next(req_pc);
        end else begin
            if_id_valid_inst <= 1'b0;
            if_id_IR         <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences
// and a randomized run checked against an instruction-stream reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stall;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic [31:0] if_id_IR, if_id_PC, if_id_NPC;
    logic        if_id_valid_inst;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOOP_INST)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_stall         (id_stall),
        .ex_take_branch   (ex_take_branch),
        .ex_target_pc     (ex_target_pc),
        .imem             (imem),
        .if_id_IR         (if_id_IR),
        .if_id_PC         (if_id_PC),
        .if_id_NPC        (if_id_NPC),
        .if_id_valid_inst (if_id_valid_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        int          lat;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] npc;
    } obs_t;

    int vectors = 0;
    int errors  = 0;

    // memory model: one pending read, answered after a per-request latency
    bit          mem_pending;
    logic [31:0] mem_addr;
    int          mem_cnt;

    // reference model: the architectural instruction stream decode must see
    logic [31:0] exp_pc;
    bit          prev_br;
    bit          prev_wait;
    logic [31:0] prev_addr;
    int          delivered;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[17:2], ~a[17:2]};
    endfunction

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                                input logic rdy, input int lat, input logic e_rv,
                                input logic [31:0] e_addr, input logic e_v,
                                input logic [31:0] e_pc);
        vec_t r;
        r.st = st; r.br = br; r.tgt = tgt; r.rdy = rdy; r.lat = lat;
        r.e_rv = e_rv; r.e_addr = e_addr; r.e_v = e_v; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_pc      = RST_PC;
        prev_br     = 1'b0;
        prev_wait   = 1'b0;
        prev_addr   = '0;
        mem_pending = 1'b0;
        mem_cnt     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},     32'(if_id_valid_inst), 32'd0);
        check({tag, "_ir"},        if_id_IR, NOOP_INST);
        check({tag, "_pc"},        if_id_PC, RST_PC);
        check({tag, "_npc"},       if_id_NPC, RST_PC + 32'd4);
        check({tag, "_req_valid"}, 32'(imem.imem_req_valid), 32'd0);
    endtask

    // Ends at a falling edge with reset just released
    task automatic do_reset();
        rst = 1'b0;
        id_stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = '0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, run the
    // stream model, advance the memory model, return at the next falling edge.
    task automatic tick(input logic st, input logic br, input logic [31:0] tgt,
                        input logic rdy, input int lat, output obs_t o);
        bit rsp, acc;
        rsp = mem_pending && (mem_cnt == 1);
        id_stall = st; ex_take_branch = br; ex_target_pc = tgt;
        imem.imem_req_ready = rdy;
        imem.imem_rsp_valid = rsp;
        imem.imem_rsp_data  = rsp ? inst_of(mem_addr) : $urandom();
        #1;
        o.rv = imem.imem_req_valid; o.addr = imem.imem_req_addr;
        o.v = if_id_valid_inst; o.ir = if_id_IR; o.pc = if_id_PC; o.npc = if_id_NPC;

        if (prev_br) check("squash_valid", 32'(o.v), 32'd0);
        if (o.v) begin
            check("seq_pc",  o.pc,  exp_pc);
            check("seq_ir",  o.ir,  inst_of(exp_pc));
            check("seq_npc", o.npc, exp_pc + 32'd4);
        end else begin
            check("bubble_ir", o.ir, NOOP_INST);
        end
        if (prev_wait) begin
            check("req_stable_valid", 32'(o.rv), 32'd1);
            check("req_stable_addr",  o.addr, prev_addr);
        end
        acc = o.rv && rdy;
        if (acc) check("one_outstanding", 32'(mem_pending && !rsp), 32'd0);

        if (br) exp_pc = {tgt[31:2], 2'b00};
        else if (o.v && !st) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        prev_br   = br;
        prev_wait = o.rv && !rdy && !br;
        prev_addr = o.addr;

        if (rsp) mem_pending = 1'b0;
        else if (mem_pending) mem_cnt--;
        if (acc) begin
            mem_pending = 1'b1;
            mem_addr    = o.addr;
            mem_cnt     = lat;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        obs_t o;

        // stall on the PC 8 response, redirect while waiting, redirect with response
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h000, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h004, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h008, 1, 32'h000));
        tbl.push_back(mk(1, 0, 0,            1, 1, 0, 0,       1, 32'h004));
        tbl.push_back(mk(1, 0, 0,            1, 1, 0, 0,       1, 32'h004));
        tbl.push_back(mk(1, 0, 0,            1, 1, 0, 0,       1, 32'h004));
        tbl.push_back(mk(0, 0, 0,            1, 1, 0, 0,       1, 32'h004));
        tbl.push_back(mk(0, 0, 0,            1, 2, 1, 32'h00C, 1, 32'h008));
        tbl.push_back(mk(0, 1, 32'h103,      1, 1, 0, 0,       0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 0, 0,       0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h100, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h104, 0, 0));
        tbl.push_back(mk(0, 1, 32'h040,      1, 1, 0, 0,       1, 32'h100));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h040, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h044, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 1, 1, 32'h048, 1, 32'h040));

        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].lat, o);
            check("tbl_req_valid", 32'(o.rv), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) check("tbl_req_addr", o.addr, tbl[i].e_addr);
            check("tbl_valid", 32'(o.v), 32'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                check("tbl_pc",  o.pc,  tbl[i].e_pc);
                check("tbl_ir",  o.ir,  inst_of(tbl[i].e_pc));
                check("tbl_npc", o.npc, tbl[i].e_pc + 32'd4);
            end else begin
                check("tbl_nop", o.ir, NOOP_INST);
            end
        end

        // wrap-around behind a slow memory
        do_reset();
        tick(0, 1, 32'hFFFF_FFFF, 0, 1, o);
        check("wrap_first_addr", o.addr, RST_PC);
        check("wrap_first_valid", 32'(o.rv), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 1, o);
            check("wrap_wait_addr", o.addr, 32'hFFFF_FFFC);
        end
        tick(0, 0, 0, 1, 1, o);
        check("wrap_accept_addr", o.addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 1, 1, o);
        check("wrap_next_addr", o.addr, 32'h0000_0000);
        check("wrap_next_valid", 32'(o.rv), 32'd1);
        tick(0, 0, 0, 1, 1, o);
        check("wrap_if_pc",  o.pc,  32'hFFFF_FFFC);
        check("wrap_if_npc", o.npc, 32'h0000_0000);
        tick(0, 0, 0, 1, 1, o);
        check("wrap_after_pc", o.pc, 32'h0000_0000);

        // reset asserted while a read is outstanding
        do_reset();
        tick(0, 0, 0, 1, 3, o);
        tick(0, 0, 0, 1, 1, o);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(0, 0, 0, 1, 1, o);
        check("midrst_first_valid", 32'(o.rv), 32'd1);
        check("midrst_first_addr",  o.addr, RST_PC);

        // randomized traffic against the stream model
        do_reset();
        delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            logic st, br, rdy;
            logic [31:0] tgt;
            int lat;
            st  = ($urandom_range(3) == 0);
            br  = ($urandom_range(19) == 0);
            tgt = $urandom();
            rdy = ($urandom_range(9) < 7);
            lat = ($urandom_range(3) == 0) ? int'($urandom_range(4, 2)) : 1;
            tick(st, br, tgt, rdy, lat, o);
        end
        check("liveness", 32'(delivered > 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
